// File: rtl/pipo_pkg.sv
// Shared constants and helpers for the pipo_fifo operand queue.
package pipo_pkg;

   localparam int PIPO_WIDTH_DEF = 16;
   localparam int PIPO_DEPTH_DEF = 4;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipo_fifo_if.sv
// Handshake bundle between the operand source/consumer and the FIFO.
interface pipo_fifo_if
   import pipo_pkg::*;
#(
   parameter int WIDTH = PIPO_WIDTH_DEF,
   parameter int DEPTH = PIPO_DEPTH_DEF
);

   logic                      flush;
   logic                      ld;
   logic signed [WIDTH-1:0]   data_in;
   logic                      rd;
   logic signed [WIDTH-1:0]   data_out;
   logic                      out_valid;
   logic                      full;
   logic                      empty;
   logic [ptr_w(DEPTH):0]     count;
   logic                      ovf;

   // Source/consumer side: issues writes, pops and flushes.
   modport master (
      output flush, ld, data_in, rd,
      input  data_out, out_valid, full, empty, count, ovf
   );

   // FIFO side.
   modport slave (
      input  flush, ld, data_in, rd,
      output data_out, out_valid, full, empty, count, ovf
   );

endinterface

// File: rtl/pipo_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module pipo_fifo_mem
   import pipo_pkg::*;
#(
   parameter int WIDTH = PIPO_WIDTH_DEF,
   parameter int DEPTH = PIPO_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic signed [WIDTH-1:0]   wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic signed [WIDTH-1:0]   rdata
);

   logic signed [WIDTH-1:0] mem [DEPTH];

   // Store the incoming word at the write address.
   // NOTE: the array has no reset; stale entries are never observed because
   // the control logic masks the read data whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every register sees pre-edge values.
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipo_fifo.sv
// DEPTH-entry FIFO queuing signed operands for the Booth multiplier.
// Holds pointers, occupancy, sticky overflow and the empty masking.
module pipo_fifo
   import pipo_pkg::*;
#(
   parameter int WIDTH = PIPO_WIDTH_DEF,
   parameter int DEPTH = PIPO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   pipo_fifo_if.slave  bus
);

   localparam int              PW       = ptr_w(DEPTH);
   localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic [PW:0]               cnt;
   logic                      ovf_q;
   logic                      is_full;
   logic                      is_empty;
   logic                      wr_en;
   logic                      rd_en;
   logic signed [WIDTH-1:0]   rdata;

   // Flags come from the pre-edge count, so a ld on a full FIFO is rejected
   // even when a pop happens on the same edge.
   assign is_full  = (cnt == CNT_FULL);
   assign is_empty = (cnt == '0);

   // Reset and flush outrank the write so nothing lands in memory on those edges.
   assign wr_en = rst_n && !bus.flush && bus.ld && !is_full;
   assign rd_en = bus.rd && !is_empty;

   pipo_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Pointer, occupancy and overflow bookkeeping; reset, then flush, then ld/rd.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en && !rd_en)      cnt <= cnt + CNT_ONE;
         else if (rd_en && !wr_en) cnt <= cnt - CNT_ONE;
         if (bus.ld && is_full) ovf_q <= 1'b1;
      end
   end

   // Present the head entry, forced to zero while the FIFO is empty.
   always_comb begin
      // NOTE: default first so every path assigns data_out and no latch forms.
      bus.data_out = '0;
      if (!is_empty) bus.data_out = rdata;
   end

   assign bus.out_valid = !is_empty;
   assign bus.full      = is_full;
   assign bus.empty     = is_empty;
   assign bus.count     = cnt;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipo_fifo.sv
// Self-checking bench for pipo_fifo: directed scenarios plus a random run,
// compared against a queue-based reference model.
module tb_pipo_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;

   pipo_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   pipo_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO contents as a queue plus the sticky flag.
   logic signed [WIDTH-1:0] q [$];
   logic                    m_ovf;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Compare every output against the model.
   task automatic check_model(input string tag);
      logic signed [WIDTH-1:0] exp_head;
      exp_head = (q.size() == 0) ? '0 : q[0];
      check({tag, ".count"},     32'(bus.count),     32'(q.size()));
      check({tag, ".empty"},     32'(bus.empty),     32'(q.size() == 0));
      check({tag, ".full"},      32'(bus.full),      32'(q.size() == DEPTH));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
      check({tag, ".data_out"},  32'(bus.data_out),  32'(exp_head));
      check({tag, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
   endtask

   // One clock: drive inputs, update the model by the FIFO rules, check at negedge.
   task automatic cycle(input string tag, input logic l, input logic r,
                        input logic signed [WIDTH-1:0] d,
                        input logic f = 1'b0, input logic rs = 1'b1);
      bit was_full;
      bit was_empty;
      bus.ld      = l;
      bus.rd      = r;
      bus.data_in = d;
      bus.flush   = f;
      rst_n       = rs;
      @(posedge clk);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (!rs || f) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (r && !was_empty) void'(q.pop_front());
         if (l && !was_full)  q.push_back(d);
         if (l && was_full)   m_ovf = 1'b1;
      end
      @(negedge clk);
      bus.ld    = 1'b0;
      bus.rd    = 1'b0;
      bus.flush = 1'b0;
      rst_n     = 1'b1;
      check_model(tag);
   endtask

   logic signed [WIDTH-1:0] fill_vals [4];

   initial begin
      fill_vals = '{16'sd5, -16'sd3, 16'sd32767, -16'sd32768};
      m_ovf       = 1'b0;
      rst_n       = 1'b0;
      bus.ld      = 1'b0;
      bus.rd      = 1'b0;
      bus.flush   = 1'b0;
      bus.data_in = '0;

      // Reset held two cycles, then idle.
      cycle("reset0", 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle("reset1", 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle("idle", 1'b0, 1'b0, '0);
      check("idle.count_zero", 32'(bus.count), 32'd0);
      check("idle.empty_one", 32'(bus.empty), 32'd1);

      // Fill then drain, in order.
      for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 1'b0, fill_vals[i]);
      check("fill.full_one", 32'(bus.full), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("drain.order", 32'(bus.data_out), 32'(fill_vals[i]));
         cycle("drain", 1'b0, 1'b1, '0);
      end
      check("drain.empty_one", 32'(bus.empty), 32'd1);

      // Overflow on a full FIFO; flag survives the drain, cleared by flush.
      for (int i = 1; i <= 4; i++) cycle("ovf_fill", 1'b1, 1'b0, 16'(i));
      cycle("ovf_ld", 1'b1, 1'b0, 16'sh1234);
      check("ovf.flag_set", 32'(bus.ovf), 32'd1);
      check("ovf.count_four", 32'(bus.count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("ovf.drain_order", 32'(bus.data_out), 32'(i));
         cycle("ovf_drain", 1'b0, 1'b1, '0);
      end
      check("ovf.sticky", 32'(bus.ovf), 32'd1);
      cycle("ovf_flush", 1'b0, 1'b0, '0, 1'b1);
      check("ovf.cleared", 32'(bus.ovf), 32'd0);

      // Simultaneous ld and rd at count 2, full and empty.
      cycle("sim_w", 1'b1, 1'b0, 16'sd100);
      cycle("sim_w", 1'b1, 1'b0, 16'sd101);
      cycle("sim_mid", 1'b1, 1'b1, 16'sd102);
      check("sim_mid.count_two", 32'(bus.count), 32'd2);
      check("sim_mid.head", 32'(bus.data_out), 32'sd101);
      cycle("sim_w", 1'b1, 1'b0, 16'sd103);
      cycle("sim_w", 1'b1, 1'b0, 16'sd104);
      cycle("sim_full", 1'b1, 1'b1, 16'sd105);
      check("sim_full.count_three", 32'(bus.count), 32'd3);
      check("sim_full.ovf", 32'(bus.ovf), 32'd1);
      cycle("sim_flush", 1'b0, 1'b0, '0, 1'b1);
      cycle("sim_empty", 1'b1, 1'b1, -16'sd7);
      check("sim_empty.count_one", 32'(bus.count), 32'd1);
      check("sim_empty.valid", 32'(bus.out_valid), 32'd1);
      check("sim_empty.head", 32'(bus.data_out), -32'sd7);
      cycle("wrap_pre_flush", 1'b0, 1'b0, '0, 1'b1);

      // Wrap-around: 10 write/read pairs.
      for (int i = 0; i < 10; i++) begin
         cycle("wrap_w", 1'b1, 1'b0, 16'(i));
         check("wrap.value", 32'(bus.data_out), 32'(i));
         cycle("wrap_r", 1'b0, 1'b1, '0);
      end

      // Flush with ld high at count 3.
      for (int i = 0; i < 3; i++) cycle("fl_fill", 1'b1, 1'b0, 16'(20 + i));
      cycle("fl_pulse", 1'b1, 1'b0, 16'sd77, 1'b1);
      check("flush.count_zero", 32'(bus.count), 32'd0);
      check("flush.empty_one", 32'(bus.empty), 32'd1);

      // Same with reset instead of flush.
      for (int i = 0; i < 3; i++) cycle("rs_fill", 1'b1, 1'b0, 16'(30 + i));
      cycle("rs_pulse", 1'b1, 1'b0, 16'sd88, 1'b0, 1'b0);
      check("rst.count_zero", 32'(bus.count), 32'd0);
      check("rst.empty_one", 32'(bus.empty), 32'd1);

      // Random traffic with occasional flush and reset.
      for (int n = 0; n < 400; n++) begin
         cycle("rand",
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               16'($urandom),
               1'($urandom_range(0, 40) == 0),
               1'($urandom_range(0, 60) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
